jpeg_output_stream: RTL and testbench
=====================================

# jpeg_output_stream

Drains 24-bit RGB pixels from the decoder's pixel output FIFO (valid/pop consumer side) and packs them little-endian into a 32-bit ready/valid byte stream: 4 pixels produce 3 full words. It sits between the decoder output FIFO and the SoC stream fabric or DMA. It counts pixels per frame, marks the final beat with `tlast` and a partial `tstrb`, and can abort a frame while flushing the FIFO.

## Interface
- `COUNT_W`, 32: width of the frame pixel counter.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  frame start pulse; ignored while `busy_o`=1.
- `pixels_i`  in  COUNT_W  pixel count of the frame; sampled when `start_i` is accepted.
- `abort_i`  in  1  drop the current frame; has priority over everything except reset.
- `fifo_data_i`  in  24  head-of-FIFO pixel, combinational from FIFO; byte0=[7:0], byte1=[15:8], byte2=[23:16].
- `fifo_valid_i`  in  1  FIFO non-empty.
- `fifo_pop_o`  out  1  pop head pixel this cycle.
- `fifo_flush_o`  out  1  one-cycle FIFO flush request on abort.
- `outport_tdata_o`  out  32  stream data; unused byte lanes are 0.
- `outport_tstrb_o`  out  4  valid byte lanes.
- `outport_tlast_o`  out  1  final beat of the frame.
- `outport_tvalid_o`  out  1  beat valid.
- `outport_tready_i`  in  1  sink accepts beat.
- `busy_o`  out  1  state != IDLE.
- `done_o`  out  1  one-cycle pulse at frame completion.

## Operation
- **Reset values:** all outputs 0; state=IDLE; residual count r=0; remaining pixel count=0. FIFO contents are untouched by reset.
- **IDLE:**
  - `start_i`=1 with `pixels_i`≠0 → latch the count, go to RUN.
  - `start_i`=1 with `pixels_i`=0 → `done_o` next cycle, no beats, stay IDLE.
- **Output register free:** `free` = ~tvalid | tready.
- **RUN:** `fifo_pop_o` = `fifo_valid_i` & `free` & (remaining≠0).
- **Packing state:** r ∈ {0,3,2,1} residual bytes are held in a 24-bit residual register.
- **On each pop** (r+3 bytes available):
  - r=0 → store 3 bytes, r=3, no beat.
  - r=3 → emit a full word, r=2.
  - r=2 → emit a full word, r=1.
  - r=1 → emit a full word, r=0.
- **Byte order:** oldest byte goes to lane 0.
- **Last pixel popped** (remaining=1):
  - r=1 → one full word, tlast, go to DRAIN.
  - r=0 → one partial word, strb 0111, tlast, go to DRAIN.
  - r=3 or r=2 → full word without tlast, go to FLUSH.
- **FLUSH:** when `free`, load the residual beat (strb 0011 for 2 bytes, 0001 for 1 byte), tlast=1, go to DRAIN.
- **DRAIN:** tlast beat accepted (tvalid&tready) → `done_o`=1 next cycle, state=IDLE, r=0.
- **Abort:** `abort_i` in any state → next cycle state=IDLE, tvalid=0, r=0, remaining=0, `fifo_flush_o`=1 for exactly one cycle, no `done_o`.
- **Abort vs stream protocol:** abort knowingly breaks stream valid-stability; the sink must be reset with it.
- **Handshake rule:** once asserted, tvalid/tdata/tstrb/tlast hold stable until tready, except on abort or reset.
- **Excess FIFO data:** data beyond `pixels_i` stays in the FIFO and is not popped.

## Timing
- **Pop path:** `fifo_pop_o` is combinational from `fifo_valid_i`, `outport_tready_i`, and registered state; no path from `fifo_data_i` to `fifo_pop_o`.
- **Latency:** pixel pop → beat visible on the next edge, 1 cycle.
- **Throughput:** 1 pixel/cycle with tready held high, i.e. 3 beats per 4 cycles; the FLUSH beat adds 1 cycle.
- **Back-pressure:** tready=0 with tvalid=1 → no pop, state frozen.
- **Simultaneous events:**
  - Beat accepted and new beat loaded in the same cycle: allowed, no bubble.
  - `start_i` together with `abort_i` → abort wins, start ignored.
  - `start_i` in the same cycle as `done_o` → accepted.

## Structure
- **Shared package `jpeg_output_stream_pkg`:**
  - State encoding localparams: IDLE, RUN, FLUSH, DRAIN.
  - Strobe constants: STRB_FULL=4'hF, STRB_3=4'h7, STRB_2=4'h3, STRB_1=4'h1.
- **Sub-module `jpeg_output_byte_packer`:** purely combinational.
  - Inputs: r, residual, pixel.
  - Outputs: word, emit, next r, next residual, and tail strobe.
- **Top level:** FSM, counter, and output register.
- **Size target:** roughly 200 RTL lines.

## Test plan
- **4 pixels, tready=1:** pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A → beats 0x04030201, 0x08070605, 0x0C0B0A09. All strb F, tlast on the 3rd beat, `done_o` 1 cycle after the 3rd beat.
- **5 pixels:** as above plus 0x0F0E0D → 4th beat 0x000F0E0D, strb 0111, tlast.
- **2 pixels** 0x030201, 0x060504 → beat 0x04030201 with strb F, then a FLUSH beat 0x00000605, strb 0011, tlast.
- **Random tready** (~50%) and random `fifo_valid_i`, 1000 pixels:
  - Byte stream equals the input byte stream.
  - 750 beats, tvalid-stable rule holds.
  - No pop while tvalid&~tready.
- **`pixels_i`=0** → no beats, `done_o` one cycle after start.
- **abort mid-frame** (after 2 beats, tvalid=1, tready=0) → next cycle tvalid=0, busy_o=0, `fifo_flush_o` 1-cycle pulse, no `done_o`. A new start with 4 pixels then produces correct beats from r=0.

Source files
------------

// File: rtl/jpeg_output_stream_pkg.sv
// Shared state encoding, strobe constants and residual helpers for the
// JPEG RGB pixel to 32-bit byte-stream packer.
package jpeg_output_stream_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_RUN   = RUN,
        ST_FLUSH = FLUSH,
        ST_DRAIN = DRAIN
    } state_e;

    localparam logic [3:0] STRB_FULL = 4'hF;
    localparam logic [3:0] STRB_3    = 4'h7;
    localparam logic [3:0] STRB_2    = 4'h3;
    localparam logic [3:0] STRB_1    = 4'h1;

    // Number of bytes (0..3) waiting in the residual register.
    typedef logic [1:0] resid_cnt_t;

    function automatic logic [3:0] residual_strb(input resid_cnt_t r);
        case (r)
            2'd3:    return STRB_3;
            2'd2:    return STRB_2;
            2'd1:    return STRB_1;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/jpeg_output_byte_packer.sv
// Combinational byte packer: merges r residual bytes with one 3-byte pixel,
// oldest byte in lane 0, and returns the word plus the new residual.
module jpeg_output_byte_packer
    import jpeg_output_stream_pkg::*;
(
    input  resid_cnt_t  r,
    input  logic [23:0] residual,
    input  logic [23:0] pixel,
    output logic [31:0] word,
    output logic        emit,
    output resid_cnt_t  next_r,
    output logic [23:0] next_residual,
    output logic [3:0]  tail_strb
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        word          = {8'h00, pixel};
        emit          = 1'b0;
        next_r        = 2'd3;
        next_residual = pixel;
        case (r)
            2'd3: begin
                word          = {pixel[7:0], residual};
                emit          = 1'b1;
                next_r        = 2'd2;
                next_residual = {8'h00, pixel[23:8]};
            end
            2'd2: begin
                word          = {pixel[15:0], residual[15:0]};
                emit          = 1'b1;
                next_r        = 2'd1;
                next_residual = {16'h0000, pixel[23:16]};
            end
            2'd1: begin
                word          = {pixel, residual[7:0]};
                emit          = 1'b1;
                next_r        = 2'd0;
                next_residual = 24'h000000;
            end
            default: ;
        endcase
        // Strobe of the bytes left over after this pixel, i.e. a partial tail beat.
        tail_strb = residual_strb(next_r);
    end

endmodule

// File: rtl/jpeg_output_stream.sv
// Drains 24-bit pixels from the decoder FIFO and packs them into a 32-bit
// ready/valid stream with per-frame pixel counting, tlast/tstrb and abort.
module jpeg_output_stream
    import jpeg_output_stream_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] pixels_i,
    input  logic               abort_i,
    input  logic [23:0]        fifo_data_i,
    input  logic               fifo_valid_i,
    output logic               fifo_pop_o,
    output logic               fifo_flush_o,
    output logic [31:0]        outport_tdata_o,
    output logic [3:0]         outport_tstrb_o,
    output logic               outport_tlast_o,
    output logic               outport_tvalid_o,
    input  logic               outport_tready_i,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    resid_cnt_t         r_q, r_d;
    logic [23:0]        residual_q, residual_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [31:0]        tdata_q, tdata_d;
    logic [3:0]         tstrb_q, tstrb_d;
    logic               tlast_q, tlast_d;
    logic               tvalid_q, tvalid_d;
    logic               done_q, done_d;
    logic               flush_q, flush_d;

    logic               free, pop, last_pixel;
    logic [31:0]        pk_word;
    logic               pk_emit;
    resid_cnt_t         pk_next_r;
    logic [23:0]        pk_next_residual;
    logic [3:0]         pk_tail_strb;

    jpeg_output_byte_packer u_packer (
        .r             (r_q),
        .residual      (residual_q),
        .pixel         (fifo_data_i),
        .word          (pk_word),
        .emit          (pk_emit),
        .next_r        (pk_next_r),
        .next_residual (pk_next_residual),
        .tail_strb     (pk_tail_strb)
    );

    // The output register can take a new beat when empty or being drained now.
    assign free       = ~tvalid_q | outport_tready_i;
    assign last_pixel = (remaining_q == COUNT_W'(1));
    assign pop        = (state_q == ST_RUN) & fifo_valid_i & free
                      & (remaining_q != '0) & ~abort_i;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        residual_d  = residual_q;
        remaining_d = remaining_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        done_d      = 1'b0;
        flush_d     = 1'b0;

        if (tvalid_q && outport_tready_i) tvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (pixels_i != '0) begin
                        remaining_d = pixels_i;
                        r_d         = 2'd0;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pop) begin
                    remaining_d = remaining_q - COUNT_W'(1);
                    r_d         = pk_next_r;
                    residual_d  = pk_next_residual;
                    if (last_pixel) begin
                        // r=0 and r=1 finish in this beat; r=3/2 leave bytes for FLUSH.
                        tvalid_d = 1'b1;
                        tdata_d  = pk_word;
                        if (r_q == 2'd1 || r_q == 2'd0) begin
                            tstrb_d = (r_q == 2'd1) ? STRB_FULL : pk_tail_strb;
                            tlast_d = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            tstrb_d = STRB_FULL;
                            tlast_d = 1'b0;
                            state_d = ST_FLUSH;
                        end
                    end else if (pk_emit) begin
                        tvalid_d = 1'b1;
                        tdata_d  = pk_word;
                        tstrb_d  = STRB_FULL;
                        tlast_d  = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {8'h00, residual_q};
                    tstrb_d  = residual_strb(r_q);
                    tlast_d  = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tvalid_q && outport_tready_i && tlast_q) begin
                    done_d     = 1'b1;
                    r_d        = 2'd0;
                    residual_d = 24'h000000;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            r_d         = 2'd0;
            residual_d  = 24'h000000;
            remaining_d = '0;
            done_d      = 1'b0;
            flush_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            r_q         <= 2'd0;
            residual_q  <= 24'h000000;
            remaining_q <= '0;
            tdata_q     <= 32'h0;
            tstrb_q     <= 4'h0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            residual_q  <= residual_d;
            remaining_q <= remaining_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            done_q      <= done_d;
            flush_q     <= flush_d;
        end
    end

    assign fifo_pop_o       = pop;
    assign fifo_flush_o     = flush_q;
    assign outport_tdata_o  = tdata_q;
    assign outport_tstrb_o  = tstrb_q;
    assign outport_tlast_o  = tlast_q;
    assign outport_tvalid_o = tvalid_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;

endmodule

// File: tb/tb_jpeg_output_stream.sv
// Self-checking bench for jpeg_output_stream: table-driven frames plus
// hand-written abort, zero-length and random back-pressure sequences.
`timescale 1ns/1ps
module tb_jpeg_output_stream;

    localparam int COUNT_W = 32;

    logic               clk_i    = 1'b0;
    logic               rst_ni   = 1'b0;
    logic               start_i  = 1'b0;
    logic [COUNT_W-1:0] pixels_i = '0;
    logic               abort_i  = 1'b0;
    logic [23:0]        fifo_data_i;
    logic               fifo_valid_i;
    logic               fifo_pop_o;
    logic               fifo_flush_o;
    logic [31:0]        tdata;
    logic [3:0]         tstrb;
    logic               tlast;
    logic               tvalid;
    logic               tready   = 1'b0;
    logic               busy;
    logic               done;

    jpeg_output_stream #(.COUNT_W(COUNT_W)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .pixels_i         (pixels_i),
        .abort_i          (abort_i),
        .fifo_data_i      (fifo_data_i),
        .fifo_valid_i     (fifo_valid_i),
        .fifo_pop_o       (fifo_pop_o),
        .fifo_flush_o     (fifo_flush_o),
        .outport_tdata_o  (tdata),
        .outport_tstrb_o  (tstrb),
        .outport_tlast_o  (tlast),
        .outport_tvalid_o (tvalid),
        .outport_tready_i (tready),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk_i = ~clk_i;

    // FIFO model: combinational head, pop/flush on the clock edge.
    logic [23:0] fifo_mem [0:4095];
    logic [31:0] wr_ptr   = 32'd0;
    logic [31:0] rd_ptr   = 32'd0;
    logic        vgate    = 1'b1;
    logic        drop_all = 1'b0;

    assign fifo_valid_i = (rd_ptr != wr_ptr) && vgate;
    assign fifo_data_i  = fifo_mem[rd_ptr[11:0]];

    always @(posedge clk_i) begin
        if (drop_all || fifo_flush_o) rd_ptr <= wr_ptr;
        else if (fifo_pop_o)          rd_ptr <= rd_ptr + 32'd1;
    end

    // Protocol monitor: held beats must stay stable; no pop while stalled.
    int          stab_viol = 0;
    int          pop_viol  = 0;
    logic        hold_q    = 1'b0;
    logic        abort_q   = 1'b0;
    logic [36:0] snap_q    = '0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (hold_q && !abort_q && (!tvalid || {tdata, tstrb, tlast} != snap_q))
                stab_viol <= stab_viol + 1;
            if (fifo_pop_o && tvalid && !tready)
                pop_viol <= pop_viol + 1;
        end
        hold_q  <= tvalid && !tready;
        snap_q  <= {tdata, tstrb, tlast};
        abort_q <= abort_i;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Test pixel k carries bytes 3k+1, 3k+2, 3k+3 (lane order low to high).
    function automatic logic [23:0] pix_at(input int k);
        logic [7:0] b;
        b = 8'(3 * k + 1);
        return {b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push(input logic [23:0] p);
        fifo_mem[wr_ptr[11:0]] = p;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    task automatic start_frame(input int n);
        @(posedge clk_i); #1;
        start_i  = 1'b1;
        pixels_i = COUNT_W'(n);
        @(posedge clk_i); #1;
        start_i  = 1'b0;
    endtask

    task automatic drop_fifo();
        @(posedge clk_i); #1 drop_all = 1'b1;
        @(posedge clk_i); #1 drop_all = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]       npix;
        logic [2:0]       nbeats;
        logic [4:0][31:0] data;
        logic [4:0][3:0]  strb;
    } vec_t;

    vec_t vecs [6];

    // Push npix test pixels plus 2 surplus ones, run the frame with tready=1.
    task automatic run_vec(input int idx);
        vec_t v;
        int   got;
        int   cyc;
        bit   seen_last;
        v = vecs[idx];
        got = 0;
        cyc = 0;
        seen_last = 0;
        tready = 1'b1;
        for (int i = 0; i < int'(v.npix) + 2; i++) push(pix_at(i));
        start_frame(int'(v.npix));
        while (!seen_last && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            if (tvalid && tready) begin
                if (got < int'(v.nbeats)) begin
                    check($sformatf("v%0d beat%0d data", idx, got), tdata, v.data[got]);
                    check($sformatf("v%0d beat%0d strb", idx, got), 32'(tstrb), 32'(v.strb[got]));
                    check($sformatf("v%0d beat%0d last", idx, got), 32'(tlast),
                          32'(got == int'(v.nbeats) - 1));
                end
                got++;
                if (tlast) seen_last = 1;
            end
        end
        check($sformatf("v%0d tlast seen", idx), 32'(seen_last), 32'd1);
        check($sformatf("v%0d beat count", idx), 32'(got), 32'(v.nbeats));
        @(negedge clk_i);
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d busy after", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d surplus kept", idx), wr_ptr - rd_ptr, 32'd2);
        drop_fifo();
    endtask

    task automatic run_random();
        logic [7:0]  exp_bytes [$];
        logic [7:0]  got_bytes [$];
        logic [23:0] p;
        int          beats;
        int          lasts;
        int          cyc;
        int          mism;
        bit          last_ok;
        bit          done_seen;
        beats = 0; lasts = 0; cyc = 0; mism = 0; last_ok = 0; done_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            p = 24'($urandom);
            push(p);
            exp_bytes.push_back(p[7:0]);
            exp_bytes.push_back(p[15:8]);
            exp_bytes.push_back(p[23:16]);
        end
        start_frame(1000);
        while (!done_seen && cyc < 20000) begin
            @(posedge clk_i); #1;
            tready = 1'($urandom_range(0, 1));
            vgate  = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            cyc++;
            if (done) done_seen = 1;
            if (tvalid && tready) begin
                beats++;
                if (tlast) begin
                    lasts++;
                    last_ok = (beats == 750);
                end
                for (int l = 0; l < 4; l++)
                    if (tstrb[l]) got_bytes.push_back(tdata[8*l +: 8]);
            end
        end
        tready = 1'b1;
        vgate  = 1'b1;
        check("rand done", 32'(done_seen), 32'd1);
        check("rand beats", 32'(beats), 32'd750);
        check("rand tlast count", 32'(lasts), 32'd1);
        check("rand tlast on final beat", 32'(last_ok), 32'd1);
        check("rand byte count", 32'(got_bytes.size()), 32'd3000);
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) mism++;
        check("rand byte mismatches", 32'(mism), 32'd0);
        check("rand fifo drained", wr_ptr - rd_ptr, 32'd0);
    endtask

    initial begin
        int acc;
        int cyc;
        bit done_any;

        vecs[0] = '0; vecs[0].npix = 4; vecs[0].nbeats = 3;
        vecs[0].data[0] = 32'h04030201; vecs[0].strb[0] = 4'hF;
        vecs[0].data[1] = 32'h08070605; vecs[0].strb[1] = 4'hF;
        vecs[0].data[2] = 32'h0C0B0A09; vecs[0].strb[2] = 4'hF;
        vecs[1] = vecs[0]; vecs[1].npix = 5; vecs[1].nbeats = 4;
        vecs[1].data[3] = 32'h000F0E0D; vecs[1].strb[3] = 4'h7;
        vecs[2] = '0; vecs[2].npix = 2; vecs[2].nbeats = 2;
        vecs[2].data[0] = 32'h04030201; vecs[2].strb[0] = 4'hF;
        vecs[2].data[1] = 32'h00000605; vecs[2].strb[1] = 4'h3;
        vecs[3] = '0; vecs[3].npix = 1; vecs[3].nbeats = 1;
        vecs[3].data[0] = 32'h00030201; vecs[3].strb[0] = 4'h7;
        vecs[4] = '0; vecs[4].npix = 3; vecs[4].nbeats = 3;
        vecs[4].data[0] = 32'h04030201; vecs[4].strb[0] = 4'hF;
        vecs[4].data[1] = 32'h08070605; vecs[4].strb[1] = 4'hF;
        vecs[4].data[2] = 32'h00000009; vecs[4].strb[2] = 4'h1;
        vecs[5] = vecs[0]; vecs[5].npix = 6; vecs[5].nbeats = 5;
        vecs[5].data[3] = 32'h100F0E0D; vecs[5].strb[3] = 4'hF;
        vecs[5].data[4] = 32'h00001211; vecs[5].strb[4] = 4'h3;

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("reset tvalid", 32'(tvalid), 32'd0);
        check("reset tdata", tdata, 32'd0);
        check("reset tstrb/tlast", 32'({tstrb, tlast}), 32'd0);
        check("reset busy/done", 32'({busy, done}), 32'd0);
        check("reset pop/flush", 32'({fifo_pop_o, fifo_flush_o}), 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Zero-length frame: done next cycle, nothing else.
        start_frame(0);
        check("zero done", 32'(done), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        check("zero tvalid", 32'(tvalid), 32'd0);
        @(posedge clk_i); #1;
        check("zero done pulse", 32'(done), 32'd0);

        // Abort with a beat stalled after two accepted beats.
        for (int i = 0; i < 8; i++) push(pix_at(i));
        tready = 1'b1;
        start_frame(8);
        acc = 0;
        cyc = 0;
        while (acc < 2 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
            if (tvalid && tready) acc++;
            @(posedge clk_i); #1;
            tready = (acc < 2);
        end
        @(negedge clk_i);
        check("abort pending tvalid", 32'(tvalid), 32'd1);
        check("abort pending tdata", tdata, 32'h0C0B0A09);
        @(posedge clk_i); #1 abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        check("abort tvalid", 32'(tvalid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort flush", 32'(fifo_flush_o), 32'd1);
        done_any = done;
        @(posedge clk_i); #1;
        check("abort flush pulse", 32'(fifo_flush_o), 32'd0);
        check("abort fifo flushed", wr_ptr - rd_ptr, 32'd0);
        done_any = done_any | done;
        repeat (3) begin
            @(posedge clk_i); #1;
            done_any = done_any | done;
        end
        check("abort no done", 32'(done_any), 32'd0);
        run_vec(0);

        // Start and abort together: abort wins.
        @(posedge clk_i); #1;
        start_i = 1'b1; abort_i = 1'b1; pixels_i = COUNT_W'(4);
        @(posedge clk_i); #1;
        start_i = 1'b0; abort_i = 1'b0;
        check("start+abort busy", 32'(busy), 32'd0);
        check("start+abort flush", 32'(fifo_flush_o), 32'd1);
        @(posedge clk_i); #1;

        run_random();
        check("stable while stalled", 32'(stab_viol), 32'd0);
        check("no pop while stalled", 32'(pop_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
